// File: rtl/button_fsm_pkg.sv
// ============================================================================
// Module      : button_fsm_pkg
// Description : Shared state encoding and default timing constants for the
//               button run-control command FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_fsm_pkg;

    localparam int DBL_WINDOW_DEFAULT  = 50_000_000;
    localparam int ACK_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT2 = 2'd1,
        STEP  = 2'd2,
        RUN   = 2'd3
    } cmd_state_t;

endpackage

`default_nettype wire

// File: rtl/button_cmd_fsm_rise_detect.sv
// ============================================================================
// Module      : rise_detect
// Description : Rising-edge pulse generator. The history register resets
//               high so a level already asserted at reset release is no event.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= din;
        end
    end

    assign pulse = din & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/button_cmd_fsm.sv
// ============================================================================
// Module      : button_cmd_fsm
// Description : Turns debounced presses into MIC-1 single-step / free-run
//               commands. Optional ack watchdog: BUTTON_CMD_ACK_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_cmd_fsm
    import button_fsm_pkg::*;
#(
    parameter int DBL_WINDOW  = DBL_WINDOW_DEFAULT,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_state,
    input  logic       step_ack,
    output logic       step_req,
    output logic       run_mode,
    output logic [7:0] press_count,
    output logic       ack_err
);

    localparam int                 c_WIN_W    = $clog2(DBL_WINDOW);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(DBL_WINDOW - 1);

    generate
        if (DBL_WINDOW < 2 || ACK_TIMEOUT < 2) begin : g_param_check
            $error("button_cmd_fsm: DBL_WINDOW and ACK_TIMEOUT must be >= 2");
        end
    endgenerate

    cmd_state_t         r_state;
    cmd_state_t         w_state_nxt;
    logic [c_WIN_W-1:0] r_win_cnt;
    logic [c_WIN_W-1:0] w_win_cnt_nxt;
    logic               r_step_req;
    logic               w_step_req_nxt;
    logic               r_run_mode;
    logic               w_run_mode_nxt;
    logic [7:0]         r_press_cnt;
    logic [7:0]         w_press_cnt_nxt;
    logic               w_edge;

`ifdef BUTTON_CMD_ACK_WATCHDOG_EN
    localparam int                 c_ACK_W    = $clog2(ACK_TIMEOUT);
    localparam logic [c_ACK_W-1:0] c_ACK_LAST = c_ACK_W'(ACK_TIMEOUT - 1);

    logic [c_ACK_W-1:0] r_ack_cnt;
    logic [c_ACK_W-1:0] w_ack_cnt_nxt;
    logic               r_ack_err;
    logic               w_ack_err_nxt;
`endif

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (button_state),
        .pulse (w_edge)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_win_cnt_nxt   = r_win_cnt;
        w_step_req_nxt  = r_step_req;
        w_run_mode_nxt  = r_run_mode;
        w_press_cnt_nxt = r_press_cnt;
`ifdef BUTTON_CMD_ACK_WATCHDOG_EN
        w_ack_cnt_nxt   = r_ack_cnt;
        w_ack_err_nxt   = r_ack_err;
`endif
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_nxt     = WAIT2;
                    w_win_cnt_nxt   = '0;
                    w_press_cnt_nxt = r_press_cnt + 8'd1;
                end
            end
            WAIT2: begin
                if (r_win_cnt != c_WIN_LAST) begin
                    w_win_cnt_nxt = r_win_cnt + 1'b1;
                end
                // A second press on the very last window cycle still counts.
                if (w_edge) begin
                    w_state_nxt     = RUN;
                    w_run_mode_nxt  = 1'b1;
                    w_press_cnt_nxt = r_press_cnt + 8'd1;
                end else if (r_win_cnt == c_WIN_LAST) begin
                    w_state_nxt    = STEP;
                    w_step_req_nxt = 1'b1;
`ifdef BUTTON_CMD_ACK_WATCHDOG_EN
                    w_ack_cnt_nxt  = '0;
`endif
                end
            end
            STEP: begin
                if (step_ack) begin
                    w_state_nxt    = IDLE;
                    w_step_req_nxt = 1'b0;
`ifdef BUTTON_CMD_ACK_WATCHDOG_EN
                end else if (r_ack_cnt == c_ACK_LAST) begin
                    w_state_nxt    = IDLE;
                    w_step_req_nxt = 1'b0;
                    w_ack_err_nxt  = 1'b1;
                end else begin
                    w_ack_cnt_nxt  = r_ack_cnt + 1'b1;
`endif
                end
            end
            RUN: begin
                if (w_edge) begin
                    w_state_nxt     = IDLE;
                    w_run_mode_nxt  = 1'b0;
                    w_press_cnt_nxt = r_press_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_win_cnt   <= '0;
            r_step_req  <= 1'b0;
            r_run_mode  <= 1'b0;
            r_press_cnt <= 8'd0;
`ifdef BUTTON_CMD_ACK_WATCHDOG_EN
            r_ack_cnt   <= '0;
            r_ack_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_step_req  <= w_step_req_nxt;
            r_run_mode  <= w_run_mode_nxt;
            r_press_cnt <= w_press_cnt_nxt;
`ifdef BUTTON_CMD_ACK_WATCHDOG_EN
            r_ack_cnt   <= w_ack_cnt_nxt;
            r_ack_err   <= w_ack_err_nxt;
`endif
        end
    end

    assign step_req    = r_step_req;
    assign run_mode    = r_run_mode;
    assign press_count = r_press_cnt;
`ifdef BUTTON_CMD_ACK_WATCHDOG_EN
    assign ack_err     = r_ack_err;
`else
    assign ack_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_cmd_fsm.sv
// ============================================================================
// Module      : tb_button_cmd_fsm
// Description : Directed self-checking bench for button_cmd_fsm
//               (DBL_WINDOW=8, ACK_TIMEOUT=4). Cycle n = after posedge n.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_cmd_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button_state;
    logic       step_ack;
    logic       step_req;
    logic       run_mode;
    logic [7:0] press_count;
    logic       ack_err;

    int n_cmp  = 0;
    int n_fail = 0;

    button_cmd_fsm #(
        .DBL_WINDOW  (8),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .button_state (button_state),
        .step_ack     (step_ack),
        .step_req     (step_req),
        .run_mode     (run_mode),
        .press_count  (press_count),
        .ack_err      (ack_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        button_state = 1'b0;
        step_ack     = 1'b0;
        rst_n        = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        button_state = 1'b0;
        step_ack     = 1'b0;
        rst_n        = 1'b0;
        tick();
        n_cmp++; if (step_req !== 1'b0)    begin n_fail++; $display("FAIL reset_step_req: got %b want 0", step_req); end
        n_cmp++; if (run_mode !== 1'b0)    begin n_fail++; $display("FAIL reset_run_mode: got %b want 0", run_mode); end
        n_cmp++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL reset_press_count: got %0d want 0", press_count); end
        n_cmp++; if (ack_err !== 1'b0)     begin n_fail++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_press();
        do_reset();
        button_state = 1'b1;                  // cycle 0, held 20 cycles
        tick();                               // cycle 1
        n_cmp++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL single_pc_c1: got %0d want 1", press_count); end
        repeat (7) tick();                    // cycle 8
        n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL single_req_c8: got %b want 0", step_req); end
        tick();                               // cycle 9
        n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL single_req_c9: got %b want 1", step_req); end
        repeat (3) tick();                    // cycle 12
        n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL single_req_c12: got %b want 1", step_req); end
        step_ack = 1'b1;
        tick();                               // cycle 13
        step_ack = 1'b0;
        n_cmp++; if (step_req !== 1'b0)    begin n_fail++; $display("FAIL single_req_c13: got %b want 0", step_req); end
        n_cmp++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL single_pc_c13: got %0d want 1", press_count); end
        n_cmp++; if (run_mode !== 1'b0)    begin n_fail++; $display("FAIL single_run_c13: got %b want 0", run_mode); end
        n_cmp++; if (ack_err !== 1'b0)     begin n_fail++; $display("FAIL single_ackerr_c13: got %b want 0", ack_err); end
        repeat (7) tick();                    // cycle 20
        button_state = 1'b0;
        tick();
    endtask

    task automatic test_double_press();
        logic seen_req;
        do_reset();
        button_state = 1'b1;                  // cycle 0
        tick();
        button_state = 1'b0;                  // cycle 1
        repeat (4) tick();
        button_state = 1'b1;                  // cycle 5
        tick();                               // cycle 6
        button_state = 1'b0;
        n_cmp++; if (run_mode !== 1'b1)    begin n_fail++; $display("FAIL double_run_c6: got %b want 1", run_mode); end
        n_cmp++; if (press_count !== 8'd2) begin n_fail++; $display("FAIL double_pc_c6: got %0d want 2", press_count); end
        seen_req = step_req;
        step_ack = 1'b1;                      // ack outside STEP is ignored
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 2) step_ack = 1'b0;
            seen_req = seen_req | step_req;
        end                                   // cycle 30
        n_cmp++; if (seen_req !== 1'b0) begin n_fail++; $display("FAIL double_no_req: got %b want 0", seen_req); end
        n_cmp++; if (run_mode !== 1'b1) begin n_fail++; $display("FAIL double_run_c30: got %b want 1", run_mode); end
        button_state = 1'b1;
        tick();                               // cycle 31
        button_state = 1'b0;
        n_cmp++; if (run_mode !== 1'b0)    begin n_fail++; $display("FAIL double_stop_c31: got %b want 0", run_mode); end
        n_cmp++; if (press_count !== 8'd3) begin n_fail++; $display("FAIL double_pc_c31: got %0d want 3", press_count); end
        tick();
    endtask

    task automatic test_boundary_timeout_edge();
        do_reset();
        button_state = 1'b1;                  // cycle 0
        tick();
        button_state = 1'b0;
        repeat (7) tick();
        button_state = 1'b1;                  // cycle 8: timeout cycle
        tick();                               // cycle 9
        button_state = 1'b0;
        n_cmp++; if (run_mode !== 1'b1)    begin n_fail++; $display("FAIL bnd8_run: got %b want 1", run_mode); end
        n_cmp++; if (step_req !== 1'b0)    begin n_fail++; $display("FAIL bnd8_req: got %b want 0", step_req); end
        n_cmp++; if (press_count !== 8'd2) begin n_fail++; $display("FAIL bnd8_pc: got %0d want 2", press_count); end
        repeat (3) tick();
        n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL bnd8_req_late: got %b want 0", step_req); end
    endtask

    task automatic test_boundary_step_drop();
        do_reset();
        button_state = 1'b1;                  // cycle 0
        tick();
        button_state = 1'b0;
        repeat (9) tick();
        button_state = 1'b1;                  // cycle 10: press in STEP
        tick();                               // cycle 11
        button_state = 1'b0;
        n_cmp++; if (step_req !== 1'b1)    begin n_fail++; $display("FAIL bnd10_req: got %b want 1", step_req); end
        n_cmp++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL bnd10_pc: got %0d want 1", press_count); end
        n_cmp++; if (run_mode !== 1'b0)    begin n_fail++; $display("FAIL bnd10_run: got %b want 0", run_mode); end
        step_ack = 1'b1;
        tick();                               // cycle 12
        step_ack = 1'b0;
        n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL bnd10_req_after_ack: got %b want 0", step_req); end
        repeat (3) tick();
        n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL bnd10_no_new_req: got %b want 0", step_req); end
    endtask

`ifdef BUTTON_CMD_ACK_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        button_state = 1'b1;                  // cycle 0
        tick();
        button_state = 1'b0;
        repeat (8) tick();                    // cycle 9
        n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL wd_req_c9: got %b want 1", step_req); end
        repeat (3) tick();                    // cycle 12
        n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL wd_req_c12: got %b want 1", step_req); end
        n_cmp++; if (ack_err !== 1'b0)  begin n_fail++; $display("FAIL wd_err_c12: got %b want 0", ack_err); end
        tick();                               // cycle 13
        n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL wd_req_c13: got %b want 0", step_req); end
        n_cmp++; if (ack_err !== 1'b1)  begin n_fail++; $display("FAIL wd_err_c13: got %b want 1", ack_err); end
        button_state = 1'b1;                  // FSM back in IDLE accepts a press
        tick();
        button_state = 1'b0;
        n_cmp++; if (press_count !== 8'd2) begin n_fail++; $display("FAIL wd_pc_idle: got %0d want 2", press_count); end
        repeat (3) tick();
        n_cmp++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL wd_err_sticky: got %b want 1", ack_err); end
    endtask
`else
    task automatic test_no_watchdog();
        do_reset();
        button_state = 1'b1;                  // cycle 0
        tick();
        button_state = 1'b0;
        repeat (8) tick();                    // cycle 9
        n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL nowd_req_c9: got %b want 1", step_req); end
        repeat (100) tick();
        n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL nowd_req_c109: got %b want 1", step_req); end
        n_cmp++; if (ack_err !== 1'b0)  begin n_fail++; $display("FAIL nowd_err: got %b want 0", ack_err); end
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL nowd_req_after_ack: got %b want 0", step_req); end
    endtask
`endif

    task automatic test_reset_mid_step();
        do_reset();
        button_state = 1'b1;                  // cycle 0
        tick();
        button_state = 1'b0;
        repeat (9) tick();                    // cycle 10, in STEP
        n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL rststep_pre: got %b want 1", step_req); end
        #2;
        rst_n = 1'b0;                         // mid-cycle, no clock edge
        #1;
        n_cmp++; if (step_req !== 1'b0)    begin n_fail++; $display("FAIL rststep_async_req: got %b want 0", step_req); end
        n_cmp++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL rststep_async_pc: got %0d want 0", press_count); end
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL rststep_stays_low: got %b want 0", step_req); end
    endtask

    task automatic test_held_at_reset();
        button_state = 1'b1;
        step_ack     = 1'b0;
        rst_n        = 1'b0;
        tick();
        rst_n = 1'b1;                         // release with button held high
        repeat (4) tick();
        n_cmp++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL held_pc: got %0d want 0", press_count); end
        button_state = 1'b0;
        tick();
        button_state = 1'b1;
        tick();
        button_state = 1'b0;
        n_cmp++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL held_next_press: got %0d want 1", press_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            button_state = 1'b1;
            tick();
            button_state = 1'b0;
            tick();
            if (i == 254) begin
                n_cmp++; if (press_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", press_count); end
            end
        end
        n_cmp++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want 0", press_count); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_double_press();
        test_boundary_timeout_edge();
        test_boundary_step_drop();
`ifdef BUTTON_CMD_ACK_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        test_reset_mid_step();
        test_held_at_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
